// File: rtl/renode_ahb_subordinate_bridge.sv
// AHB-Lite subordinate that forwards each transfer as a single-outstanding
// valid/ready request toward the Renode backend and returns its response on the bus.
module renode_ahb_subordinate_bridge #(
    parameter int AddressWidth  = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 0
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic                      hsel,
    input  logic [AddressWidth-1:0]   haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [DataWidth-1:0]      hwdata,
    input  logic                      hready,
    output logic                      hreadyout,
    output logic                      hresp,
    output logic [DataWidth-1:0]      hrdata,
    output logic                      req_valid,
    input  logic                      req_ready,
    output logic                      req_write,
    output logic [AddressWidth-1:0]   req_addr,
    output logic [2:0]                req_size,
    output logic [DataWidth/8-1:0]    req_strb,
    output logic [DataWidth-1:0]      req_wdata,
    input  logic                      rsp_valid,
    input  logic                      rsp_error,
    input  logic [DataWidth-1:0]      rsp_rdata
);

    localparam int STRB_W = DataWidth / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int CNT_W  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_t;

    function automatic logic is_legal(input logic [2:0] size, input logic [LANE_W-1:0] lane);
        int nbytes;
        nbytes = 1 << size;
        if (nbytes > STRB_W) return 1'b0;
        return ((int'(lane) & (nbytes - 1)) == 0);
    endfunction

    function automatic logic [STRB_W-1:0] strb_of(input logic [2:0] size, input logic [LANE_W-1:0] lane);
        logic [STRB_W-1:0] m;
        m = '0;
        for (int i = 0; i < STRB_W; i++) begin
            if (i < (1 << size)) m[i] = 1'b1;
        end
        return m << lane;
    endfunction

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_first;
    logic [DataWidth-1:0]     r_wdata;
    logic [AddressWidth-1:0]  r_addr;
    logic                     r_write;
    logic [2:0]               r_size;
    logic [STRB_W-1:0]        r_strb;
    logic [DataWidth-1:0]     r_hrdata;
    logic                     r_stale;
    logic [CNT_W-1:0]         r_cnt;
    logic                     w_accept;
    logic                     w_legal;
    logic                     w_rsp_live;
    logic                     w_timeout;

    // Acceptance is only possible while the bus sees this subordinate as ready.
    assign w_accept   = hsel & hready & htrans[1] &
                        ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR2));
    assign w_legal    = is_legal(hsize, haddr[LANE_W-1:0]);
    assign w_rsp_live = (r_state == S_WAIT) & rsp_valid & ~r_stale;
    assign w_timeout  = (TimeoutCycles != 0) & (r_state == S_WAIT) & ~w_rsp_live & (r_cnt == TO_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (w_accept) w_next = w_legal ? S_ISSUE : S_ERR1;
                else          w_next = S_IDLE;
            end
            S_ISSUE: if (req_ready) w_next = S_WAIT;
            S_WAIT: begin
                if (w_rsp_live)     w_next = rsp_error ? S_ERR1 : S_DONE;
                else if (w_timeout) w_next = S_ERR1;
            end
            S_ERR1:  w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state  <= S_IDLE;
            r_first  <= 1'b0;
            r_wdata  <= '0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_strb   <= '0;
            r_hrdata <= '0;
            r_stale  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            r_first <= (w_next == S_ISSUE) && (r_state != S_ISSUE);
            if (r_first) r_wdata <= hwdata;
            if (w_accept) begin
                r_addr  <= haddr;
                r_write <= hwrite;
                r_size  <= hsize;
                r_strb  <= strb_of(hsize, haddr[LANE_W-1:0]);
            end
            if (r_state == S_ISSUE)     r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
            // A timed-out request leaves one response in flight that must be discarded.
            if (w_timeout)      r_stale <= 1'b1;
            else if (rsp_valid) r_stale <= 1'b0;
            if (w_rsp_live && !rsp_error && !r_write) r_hrdata <= rsp_rdata;
        end
    end

    assign hreadyout = ~((r_state == S_ISSUE) | (r_state == S_WAIT) | (r_state == S_ERR1));
    assign hresp     = (r_state == S_ERR1) | (r_state == S_ERR2);
    assign hrdata    = r_hrdata;
    assign req_valid = (r_state == S_ISSUE);
    assign req_write = r_write;
    assign req_addr  = r_addr;
    assign req_size  = r_size;
    assign req_strb  = r_strb;
    // hwdata only becomes valid in the first data-phase cycle, so pass it through then.
    assign req_wdata = r_first ? hwdata : r_wdata;

endmodule

// File: tb/tb_renode_ahb_subordinate_bridge.sv
// Directed bench: a 32-bit instance with an 8-cycle timeout and a 64-bit instance
// without timeout share one bus; hsel picks which one a transfer targets.
module tb_renode_ahb_subordinate_bridge;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hsel32 = 1'b0, hsel64 = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = '0;
    logic [63:0] hwdata = '0;
    logic        hready = 1'b1;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0, rsp_error = 1'b0;
    logic [63:0] rsp_rdata = '0;

    logic        a_hreadyout, a_hresp, a_req_valid, a_req_write;
    logic [31:0] a_hrdata, a_req_addr, a_req_wdata;
    logic [2:0]  a_req_size;
    logic [3:0]  a_req_strb;
    logic        b_hreadyout, b_hresp, b_req_valid, b_req_write;
    logic [63:0] b_hrdata, b_req_wdata;
    logic [31:0] b_req_addr;
    logic [2:0]  b_req_size;
    logic [7:0]  b_req_strb;

    int errs = 0;
    int checks = 0;
    int n;

    always #5 hclk = ~hclk;

    renode_ahb_subordinate_bridge #(.AddressWidth(32), .DataWidth(32), .TimeoutCycles(8)) u32 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel32), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata[31:0]), .hready(hready),
        .hreadyout(a_hreadyout), .hresp(a_hresp), .hrdata(a_hrdata),
        .req_valid(a_req_valid), .req_ready(req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_size(a_req_size), .req_strb(a_req_strb),
        .req_wdata(a_req_wdata), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
        .rsp_rdata(rsp_rdata[31:0])
    );

    renode_ahb_subordinate_bridge #(.AddressWidth(32), .DataWidth(64), .TimeoutCycles(0)) u64 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel64), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(b_hreadyout), .hresp(b_hresp), .hrdata(b_hrdata),
        .req_valid(b_req_valid), .req_ready(req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_size(b_req_size), .req_strb(b_req_strb),
        .req_wdata(b_req_wdata), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
        .rsp_rdata(rsp_rdata)
    );

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_phase(input logic sel64, input logic [31:0] a, input logic w, input logic [2:0] s);
        hsel32 = ~sel64;
        hsel64 = sel64;
        haddr  = a;
        hwrite = w;
        hsize  = s;
        htrans = 2'b10;
    endtask

    task automatic bus_idle;
        hsel32 = 1'b0;
        hsel64 = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic test_reset;
        tick; tick;
        checks++; if (a_hreadyout !== 1'b1) begin errs++; $display("FAIL rst_hreadyout got=%0h exp=1", a_hreadyout); end
        checks++; if (a_hresp !== 1'b0) begin errs++; $display("FAIL rst_hresp got=%0h exp=0", a_hresp); end
        checks++; if (a_hrdata !== 32'h0) begin errs++; $display("FAIL rst_hrdata got=%0h exp=0", a_hrdata); end
        checks++; if (a_req_valid !== 1'b0) begin errs++; $display("FAIL rst_req_valid got=%0h exp=0", a_req_valid); end
        checks++; if ({a_req_addr, a_req_size, a_req_strb, a_req_write} !== 40'h0) begin errs++; $display("FAIL rst_req_fields got=%0h exp=0", {a_req_addr, a_req_size, a_req_strb, a_req_write}); end
        checks++; if (b_req_wdata !== 64'h0) begin errs++; $display("FAIL rst_req_wdata got=%0h exp=0", b_req_wdata); end
        hresetn = 1'b1;
        tick;
    endtask

    task automatic test_idle_busy;
        hsel32 = 1'b1; haddr = 32'h10; hsize = 3'd2; htrans = 2'b01;
        tick;
        checks++; if (a_hreadyout !== 1'b1 || a_req_valid !== 1'b0) begin errs++; $display("FAIL busy_no_action got=%0h/%0h exp=1/0", a_hreadyout, a_req_valid); end
        htrans = 2'b10; hready = 1'b0;
        tick;
        checks++; if (a_hreadyout !== 1'b1 || a_req_valid !== 1'b0) begin errs++; $display("FAIL hready_low_no_accept got=%0h/%0h exp=1/0", a_hreadyout, a_req_valid); end
        hready = 1'b1;
        bus_idle;
        tick;
    endtask

    task automatic test_read32;
        req_ready = 1'b1;
        addr_phase(1'b0, 32'h100, 1'b0, 3'd2);
        tick;
        bus_idle;
        checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h100 || a_req_strb !== 4'hF) begin errs++; $display("FAIL read32_req got=%0h/%0h/%0h exp=1/100/f", a_req_valid, a_req_addr, a_req_strb); end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (a_hreadyout == 1'b0) n++;
            tick;
        end
        rsp_valid = 1'b1; rsp_rdata = 64'h0000_0000_DEAD_BEEF;
        if (a_hreadyout == 1'b0) n++;
        tick;
        rsp_valid = 1'b0;
        checks++; if (n !== 4) begin errs++; $display("FAIL read32_wait_cycles got=%0d exp=4", n); end
        checks++; if (a_hreadyout !== 1'b1 || a_hresp !== 1'b0) begin errs++; $display("FAIL read32_done got=%0h/%0h exp=1/0", a_hreadyout, a_hresp); end
        checks++; if (a_hrdata !== 32'hDEADBEEF) begin errs++; $display("FAIL read32_hrdata got=%0h exp=deadbeef", a_hrdata); end
        tick;
        checks++; if (a_hrdata !== 32'hDEADBEEF || a_hreadyout !== 1'b1) begin errs++; $display("FAIL read32_hold got=%0h exp=deadbeef", a_hrdata); end
    endtask

    task automatic test_write64_byte;
        req_ready = 1'b0;
        addr_phase(1'b1, 32'h5, 1'b1, 3'd0);
        tick;
        bus_idle;
        hwdata = 64'h0000_A500_0000_0000;
        #1;
        checks++; if (b_req_valid !== 1'b1 || b_req_write !== 1'b1 || b_req_addr !== 32'h5) begin errs++; $display("FAIL wr64_req got=%0h/%0h/%0h exp=1/1/5", b_req_valid, b_req_write, b_req_addr); end
        checks++; if (b_req_strb !== 8'h20 || b_req_size !== 3'd0) begin errs++; $display("FAIL wr64_strb_size got=%0h/%0h exp=20/0", b_req_strb, b_req_size); end
        checks++; if (b_req_wdata[47:40] !== 8'hA5) begin errs++; $display("FAIL wr64_wdata_lane got=%0h exp=a5", b_req_wdata[47:40]); end
        tick;
        hwdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checks++; if (b_req_valid !== 1'b1 || b_req_wdata !== 64'h0000_A500_0000_0000 || b_req_strb !== 8'h20) begin errs++; $display("FAIL wr64_stable got=%0h/%0h exp=a500_0000_0000/20", b_req_wdata, b_req_strb); end
        req_ready = 1'b1;
        tick;
        checks++; if (b_req_valid !== 1'b0 || b_hreadyout !== 1'b0) begin errs++; $display("FAIL wr64_wait got=%0h/%0h exp=0/0", b_req_valid, b_hreadyout); end
        rsp_valid = 1'b1; rsp_rdata = 64'h1111_2222_3333_4444;
        tick;
        rsp_valid = 1'b0;
        checks++; if (b_hreadyout !== 1'b1 || b_hresp !== 1'b0 || b_hrdata !== 64'h0) begin errs++; $display("FAIL wr64_done got=%0h/%0h/%0h exp=1/0/0", b_hreadyout, b_hresp, b_hrdata); end
        tick;
        addr_phase(1'b1, 32'h8, 1'b0, 3'd3);
        tick;
        bus_idle;
        checks++; if (b_req_valid !== 1'b1 || b_req_strb !== 8'hFF) begin errs++; $display("FAIL rd64_dword_strb got=%0h/%0h exp=1/ff", b_req_valid, b_req_strb); end
        tick;
        rsp_valid = 1'b1; rsp_rdata = 64'h0123_4567_89AB_CDEF;
        tick;
        rsp_valid = 1'b0;
        checks++; if (b_hrdata !== 64'h0123_4567_89AB_CDEF) begin errs++; $display("FAIL rd64_hrdata got=%0h exp=0123456789abcdef", b_hrdata); end
        tick;
    endtask

    task automatic test_illegal;
        addr_phase(1'b0, 32'h3, 1'b1, 3'd1);
        tick;
        bus_idle;
        checks++; if (a_hresp !== 1'b1 || a_hreadyout !== 1'b0 || a_req_valid !== 1'b0) begin errs++; $display("FAIL illegal_err1 got=%0h/%0h/%0h exp=1/0/0", a_hresp, a_hreadyout, a_req_valid); end
        tick;
        checks++; if (a_hresp !== 1'b1 || a_hreadyout !== 1'b1 || a_req_valid !== 1'b0) begin errs++; $display("FAIL illegal_err2 got=%0h/%0h/%0h exp=1/1/0", a_hresp, a_hreadyout, a_req_valid); end
        tick;
        checks++; if (a_hresp !== 1'b0 || a_hreadyout !== 1'b1) begin errs++; $display("FAIL illegal_after got=%0h/%0h exp=0/1", a_hresp, a_hreadyout); end
        addr_phase(1'b0, 32'h8, 1'b0, 3'd3);
        tick;
        bus_idle;
        checks++; if (a_hresp !== 1'b1 || a_req_valid !== 1'b0) begin errs++; $display("FAIL oversize_err got=%0h/%0h exp=1/0", a_hresp, a_req_valid); end
        tick; tick;
    endtask

    task automatic test_rsp_error;
        req_ready = 1'b1;
        addr_phase(1'b0, 32'h200, 1'b0, 3'd2);
        tick;
        bus_idle;
        tick;
        rsp_valid = 1'b1; rsp_error = 1'b1; rsp_rdata = 64'h1234_5678;
        tick;
        rsp_valid = 1'b0; rsp_error = 1'b0;
        checks++; if (a_hresp !== 1'b1 || a_hreadyout !== 1'b0 || a_hrdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rsperr_err1 got=%0h/%0h/%0h exp=1/0/deadbeef", a_hresp, a_hreadyout, a_hrdata); end
        addr_phase(1'b0, 32'h104, 1'b0, 3'd2);
        tick;
        checks++; if (a_hresp !== 1'b1 || a_hreadyout !== 1'b1 || a_hrdata !== 32'hDEADBEEF) begin errs++; $display("FAIL rsperr_err2 got=%0h/%0h/%0h exp=1/1/deadbeef", a_hresp, a_hreadyout, a_hrdata); end
    endtask

    task automatic test_back_to_back;
        tick;
        bus_idle;
        checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h104 || a_hresp !== 1'b0) begin errs++; $display("FAIL b2b_after_err got=%0h/%0h/%0h exp=1/104/0", a_req_valid, a_req_addr, a_hresp); end
        tick;
        rsp_valid = 1'b1; rsp_rdata = 64'hCAFE_F00D;
        tick;
        rsp_valid = 1'b0;
        checks++; if (a_hreadyout !== 1'b1 || a_hrdata !== 32'hCAFEF00D) begin errs++; $display("FAIL b2b_min_latency got=%0h/%0h exp=1/cafef00d", a_hreadyout, a_hrdata); end
        addr_phase(1'b0, 32'h108, 1'b1, 3'd2);
        tick;
        bus_idle;
        hwdata = 64'h1122_3344;
        #1;
        checks++; if (a_req_valid !== 1'b1 || a_req_write !== 1'b1 || a_req_addr !== 32'h108 || a_req_wdata !== 32'h11223344) begin errs++; $display("FAIL b2b_after_done got=%0h/%0h/%0h/%0h exp=1/1/108/11223344", a_req_valid, a_req_write, a_req_addr, a_req_wdata); end
        tick;
        rsp_valid = 1'b1; rsp_rdata = 64'h5555_5555;
        tick;
        rsp_valid = 1'b0;
        checks++; if (a_hreadyout !== 1'b1 || a_hrdata !== 32'hCAFEF00D) begin errs++; $display("FAIL b2b_write_keeps_hrdata got=%0h/%0h exp=1/cafef00d", a_hreadyout, a_hrdata); end
        tick;
    endtask

    task automatic test_timeout;
        req_ready = 1'b1;
        addr_phase(1'b0, 32'h300, 1'b0, 3'd2);
        tick;
        bus_idle;
        tick;
        n = 0;
        while (a_hresp !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        checks++; if (n !== 8) begin errs++; $display("FAIL timeout_cycles got=%0d exp=8", n); end
        checks++; if (a_hreadyout !== 1'b0) begin errs++; $display("FAIL timeout_err1 got=%0h exp=0", a_hreadyout); end
        tick;
        checks++; if (a_hresp !== 1'b1 || a_hreadyout !== 1'b1) begin errs++; $display("FAIL timeout_err2 got=%0h/%0h exp=1/1", a_hresp, a_hreadyout); end
        tick;
        addr_phase(1'b0, 32'h304, 1'b0, 3'd2);
        tick;
        bus_idle;
        tick;
        rsp_valid = 1'b1; rsp_rdata = 64'hBAD0_BAD0;
        tick;
        rsp_valid = 1'b0;
        checks++; if (a_hreadyout !== 1'b0 || a_hrdata !== 32'hCAFEF00D) begin errs++; $display("FAIL stale_dropped got=%0h/%0h exp=0/cafef00d", a_hreadyout, a_hrdata); end
        tick;
        rsp_valid = 1'b1; rsp_rdata = 64'h600D_600D;
        tick;
        rsp_valid = 1'b0;
        checks++; if (a_hreadyout !== 1'b1 || a_hresp !== 1'b0 || a_hrdata !== 32'h600D600D) begin errs++; $display("FAIL stale_next_read got=%0h/%0h/%0h exp=1/0/600d600d", a_hreadyout, a_hresp, a_hrdata); end
        tick;
    endtask

    task automatic test_async_reset;
        req_ready = 1'b1;
        addr_phase(1'b0, 32'h400, 1'b0, 3'd2);
        tick;
        bus_idle;
        tick;
        #2;
        hresetn = 1'b0;
        #1;
        checks++; if (a_hreadyout !== 1'b1 || a_hresp !== 1'b0 || a_req_valid !== 1'b0 || a_hrdata !== 32'h0) begin errs++; $display("FAIL async_reset got=%0h/%0h/%0h/%0h exp=1/0/0/0", a_hreadyout, a_hresp, a_req_valid, a_hrdata); end
        tick;
        hresetn = 1'b1;
        tick;
        addr_phase(1'b0, 32'h40C, 1'b0, 3'd2);
        tick;
        bus_idle;
        tick;
        rsp_valid = 1'b1; rsp_rdata = 64'hA1B2_C3D4;
        tick;
        rsp_valid = 1'b0;
        checks++; if (a_hreadyout !== 1'b1 || a_hresp !== 1'b0 || a_hrdata !== 32'hA1B2C3D4) begin errs++; $display("FAIL post_reset_read got=%0h/%0h/%0h exp=1/0/a1b2c3d4", a_hreadyout, a_hresp, a_hrdata); end
        tick;
    endtask

    initial begin
        test_reset;
        test_idle_busy;
        test_read32;
        test_write64_byte;
        test_illegal;
        test_rsp_error;
        test_back_to_back;
        test_timeout;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
